data_mem_unit: RTL and testbench
================================

// Module: data_mem_unit
// PURPOSE
// - Parametrised data memory for the RV32I core, with a valid/ready request and a one-cycle response pulse.
// - Supports programmable wait states.
// - Supports byte, halfword and word loads and stores (LB/LH/LW/LBU/LHU/SB/SH).
// - Checks misalignment, illegal width and out-of-range addresses.
// - Sits between the core's load/store path and the data array; the core stalls while busy=1.
// PARAMETERS
// ADDR_W       8             word-index bits; array depth = 2**ADDR_W 32-bit words
// WAIT_CYCLES  2             extra wait cycles per legal access, range 0..15
// BASE_ADDR    32'h0000_0000 byte address of word 0; must be word aligned
// PORTS
// clk          in   1   clock, rising edge
// rst          in   1   reset, synchronous, active-high
// req_valid    in   1   request present; requester holds all req_* stable until accepted
// req_ready    out  1   unit can accept; 1 only in IDLE
// req_we       in   1   1 = store, 0 = load
// req_funct3   in   3   RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
// req_addr     in   32  byte address
// req_wdata    in   32  store data, right-aligned (SB uses [7:0], SH uses [15:0])
// resp_valid   out  1   one-cycle response pulse
// resp_rdata   out  32  load result, extended to 32 bits; 0 for stores and errors
// resp_err     out  1   access fault, valid when resp_valid=1
// busy         out  1   1 when state != IDLE
// BEHAVIOUR
// - Reset state: state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
// - Array contents are not reset.
// - Handshake: accept when req_valid && req_ready. Latch we, funct3, addr, wdata.
// - req_valid while req_ready=0 is ignored; no queueing and no double accept.
// - FSM IDLE -> WAIT -> RESP -> IDLE:
//   - IDLE, legal accept: go to WAIT with cnt=WAIT_CYCLES-1, or to RESP if WAIT_CYCLES==0.
//   - IDLE, illegal accept: go to RESP with err=1 immediately; wait states are skipped.
//   - WAIT: decrement cnt; at cnt==0 go to RESP.
//   - RESP: drive resp_valid=1 for exactly one cycle, then return to IDLE.
//   - IDLE with no accept: stay in IDLE.
// - Latency (accept edge at cycle N):
//   - legal access: resp_valid at cycle N+1+WAIT_CYCLES;
//   - error: resp_valid at cycle N+1.
//   - Throughput: one request per WAIT_CYCLES+2 cycles.
// - Error (err=1) when any of the following holds:
//   - funct3 is in {011,110,111};
//   - store with funct3 in {100,101};
//   - H/HU with addr[0]=1;
//   - W with addr[1:0]!=0;
//   - (addr-BASE_ADDR) >= 4*2**ADDR_W, compared unsigned on 32 bits, so addresses below BASE wrap high and fault.
// - An error never writes the array; resp_rdata=0.
// - Commit: the store write and the load capture both happen on the edge that enters RESP.
// - Word index = (addr-BASE_ADDR)[ADDR_W+1:2].
// - Store byte enables:
//   - SB: lane addr[1:0] <- wdata[7:0];
//   - SH: lanes {addr[1],0} and {addr[1],1} <- wdata[15:0];
//   - SW: all four lanes.
//   - Unselected lanes keep their old value.
// - Load extraction:
//   - B/BU select lane addr[1:0]; H/HU select half addr[1]; W takes the whole word.
//   - B/H are sign-extended; BU/HU are zero-extended.
// - Reset mid-operation:
//   - rst has priority over every transition.
//   - A pending request is dropped: no write, no resp_valid. State is IDLE on the next cycle.
// - rst on the commit edge suppresses the write.
// - resp_rdata and resp_err hold their values outside RESP; they are only meaningful when resp_valid=1.
// STRUCTURE
// - Package dmem_pkg holds:
//   - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
//   - state enum {S_IDLE, S_WAIT, S_RESP};
//   - function be_gen(funct3, addr[1:0]) -> [3:0] byte enable;
//   - function ld_extract(funct3, addr[1:0], word) -> [31:0].
// - Sub-module dmem_array: 2**ADDR_W x 32, asynchronous read, synchronous write with 4-bit byte enable.
// - The top level holds the FSM, the wait counter, the request latch and the legality check.
// TESTING (ADDR_W=8, WAIT_CYCLES=2, BASE_ADDR=0, accept at cycle N)
// 1. SW 0x12345678 @0x10 -> resp_valid at N+3, err=0. LW @0x10 -> 0x12345678. req_ready=0 during N+1..N+3.
// 2. SB 0xAB @0x11 -> LW @0x10 = 0x1234AB78; LB @0x11 = 0xFFFFFFAB; LBU @0x11 = 0x000000AB.
// 3. SH 0x8001 @0x12 -> LH @0x12 = 0xFFFF8001; LHU @0x12 = 0x00008001; LW @0x10 = 0x8001AB78.
// 4. Faults, each with resp_valid at N+1, err=1, rdata=0:
//    - LW @0x13;
//    - SH @0x11 (LW @0x10 still 0x8001AB78 afterwards);
//    - LW @0x400;
//    - funct3=011;
//    - store with funct3=100.
// 5. Hold req_valid high through busy with the same SW -> exactly one accept and one resp_valid pulse.
//    Repeat with WAIT_CYCLES=0 -> resp_valid at N+1.
// 6. SW 0xDEADBEEF @0x20 (old value 0x0) with rst=1 at N+1 -> IDLE at N+2, no resp_valid, LW @0x20 = 0x0.
//    Also assert rst on the commit edge -> no write.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the RV32I data memory unit: funct3 encodings, FSM states,
// and the byte-lane helpers used for stores and loads.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] lane);
        logic [3:0] be;
        case (funct3)
            F3_B, F3_BU: be = 4'b0001 << lane;
            F3_H, F3_HU: be = lane[1] ? 4'b1100 : 4'b0011;
            F3_W:        be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data into every lane; the byte enables pick the live ones.
    function automatic logic [31:0] st_align(input logic [2:0] funct3, input logic [31:0] wdata);
        logic [31:0] data;
        case (funct3)
            F3_B, F3_BU: data = {4{wdata[7:0]}};
            F3_H, F3_HU: data = {2{wdata[15:0]}};
            default:     data = wdata;
        endcase
        return data;
    endfunction

    function automatic logic [31:0] ld_extract(input logic [2:0] funct3, input logic [1:0] lane,
                                               input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] data;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    data = {{24{b[7]}}, b};
            F3_BU:   data = {24'h0, b};
            F3_H:    data = {{16{h[15]}}, h};
            F3_HU:   data = {16'h0, h};
            F3_W:    data = word;
            default: data = 32'h0;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data array: asynchronous read, synchronous byte-enabled write.
module dmem_array #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    // NOTE: the storage has no reset; clearing a RAM would cost a port and a sweep, and software initialises it.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_unit.sv
// Data memory front end for the RV32I load/store path: request latch, legality check,
// wait-state FSM and the one-cycle response.
module data_mem_unit
    import dmem_pkg::*;
#(
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    // 33 bits so that ADDR_W=30 (a full 4 GiB window) still has a representable limit.
    localparam logic [32:0] LIMIT     = 33'd4 << ADDR_W;
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        commit;
    logic        accept;

    logic        lat_we;
    logic [2:0]  lat_funct3;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        cur_we;
    logic [2:0]  cur_funct3;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [31:0] off;
    logic        f3_ok, align_ok, legal;

    logic        mem_we;
    logic [31:0] mem_rdata;

    assign req_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign accept     = req_valid && req_ready;

    // In IDLE the request is still on the bus; afterwards only the latched copy is valid.
    assign cur_we     = req_ready ? req_we     : lat_we;
    assign cur_funct3 = req_ready ? req_funct3 : lat_funct3;
    assign cur_addr   = req_ready ? req_addr   : lat_addr;
    assign cur_wdata  = req_ready ? req_wdata  : lat_wdata;
    assign off        = cur_addr - BASE_ADDR;

    always_comb begin
        f3_ok    = 1'b0;
        align_ok = 1'b0;
        case (cur_funct3)
            F3_B, F3_BU: begin
                f3_ok    = 1'b1;
                align_ok = 1'b1;
            end
            F3_H, F3_HU: begin
                f3_ok    = 1'b1;
                align_ok = !off[0];
            end
            F3_W: begin
                f3_ok    = 1'b1;
                align_ok = (off[1:0] == 2'b00);
            end
            default: ;
        endcase
        legal = f3_ok && align_ok && !(cur_we && cur_funct3[2]) && ({1'b0, off} < LIMIT);
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!legal || WAIT_CYCLES == 0) begin
                        state_nxt = S_RESP;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_RESP;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // A reset landing on the commit edge must not leave a half-completed store behind.
    assign mem_we = commit && legal && cur_we && !rst;

    dmem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .we    (mem_we),
        .be    (be_gen(cur_funct3, off[1:0])),
        .addr  (off[ADDR_W+1:2]),
        .wdata (st_align(cur_funct3, cur_wdata)),
        .rdata (mem_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (commit) begin
                resp_err   <= !legal;
                resp_rdata <= (legal && !cur_we) ? ld_extract(cur_funct3, off[1:0], mem_rdata) : 32'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we     <= req_we;
            lat_funct3 <= req_funct3;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: directed vector table, hold/reset sequences and a random
// phase checked against a byte-level memory model (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances).
module tb_data_mem_unit;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;

    logic        ready_a, rvalid_a, err_a, busy_a;
    logic [31:0] rdata_a;
    logic        ready_b, rvalid_b, err_b, busy_b;
    logic [31:0] rdata_b;

    logic        req_ready, resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;
    int n_pulse = 0;

    logic [7:0] mdl [2][1024];

    always #5 clk = ~clk;

    data_mem_unit #(.ADDR_W(8), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && !sel), .req_ready(ready_a), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rvalid_a), .resp_rdata(rdata_a), .resp_err(err_a), .busy(busy_a)
    );

    data_mem_unit #(.ADDR_W(8), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel), .req_ready(ready_b), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rvalid_b), .resp_rdata(rdata_b), .resp_err(err_b), .busy(busy_b)
    );

    assign req_ready  = sel ? ready_b  : ready_a;
    assign resp_valid = sel ? rvalid_b : rvalid_a;
    assign resp_rdata = sel ? rdata_b  : rdata_a;
    assign resp_err   = sel ? err_b    : err_a;
    assign busy       = sel ? busy_b   : busy_a;

    always @(negedge clk) begin
        if (req_valid && req_ready) n_acc++;
        if (resp_valid) n_pulse++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Byte-addressed reference: sizes, alignment and range straight from the access rules.
    task automatic model_apply(input bit s, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err);
        int          size;
        bit          bad;
        logic [31:0] v;
        bad  = 1'b0;
        size = 1;
        case (f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default:        bad  = 1'b1;
        endcase
        err   = bad || (we && f3[2]) || (addr % size != 0) || (addr >= 32'd1024);
        rdata = 32'h0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < size; i++) mdl[s][addr[9:0] + 10'(i)] = wdata[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < size; i++) v = v | ({24'h0, mdl[s][addr[9:0] + 10'(i)]} << (8*i));
                if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
                if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
                rdata = v;
            end
        end
    endtask

    // Drives one request; lat counts negedges after the accept edge up to resp_valid (-1 on timeout).
    task automatic do_txn(input bit s, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input bit hold,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output bit rdy_low);
        sel = s;
        @(posedge clk); #1;
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        lat = -1; rdata = 'x; err = 1'bx; rdy_low = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (req_ready) rdy_low = 1'b0;
            if (resp_valid) begin
                lat = i; rdata = resp_rdata; err = resp_err;
                break;
            end
        end
        #1 req_valid = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, mrd;
        logic        er, mer;
        int          lat;
        bit          rl;

        vecs[0]  = '{1'b1, LW,     32'h10,  32'h12345678, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, LW,     32'h10,  32'h0,        32'h12345678, 1'b0};
        vecs[2]  = '{1'b1, LB,     32'h11,  32'h000000AB, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, LW,     32'h10,  32'h0,        32'h1234AB78, 1'b0};
        vecs[4]  = '{1'b0, LB,     32'h11,  32'h0,        32'hFFFFFFAB, 1'b0};
        vecs[5]  = '{1'b0, LBU,    32'h11,  32'h0,        32'h000000AB, 1'b0};
        vecs[6]  = '{1'b1, LH,     32'h12,  32'h00008001, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, LH,     32'h12,  32'h0,        32'hFFFF8001, 1'b0};
        vecs[8]  = '{1'b0, LHU,    32'h12,  32'h0,        32'h00008001, 1'b0};
        vecs[9]  = '{1'b0, LW,     32'h10,  32'h0,        32'h8001AB78, 1'b0};
        vecs[10] = '{1'b0, LW,     32'h13,  32'h0,        32'h0,        1'b1};
        vecs[11] = '{1'b1, LH,     32'h11,  32'h0000FFFF, 32'h0,        1'b1};
        vecs[12] = '{1'b0, LW,     32'h10,  32'h0,        32'h8001AB78, 1'b0};
        vecs[13] = '{1'b0, LW,     32'h400, 32'h0,        32'h0,        1'b1};
        vecs[14] = '{1'b0, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1};
        vecs[15] = '{1'b1, LBU,    32'h10,  32'h000000FF, 32'h0,        1'b1};
        vecs[16] = '{1'b0, LW,     32'h10,  32'h0,        32'h8001AB78, 1'b0};

        for (int i = 0; i < 1024; i++) begin
            mdl[0][i] = 8'h0;
            mdl[1][i] = 8'h0;
        end

        rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready_a", 32'(ready_a),  32'h1);
        check("reset_busy_a",  32'(busy_a),   32'h0);
        check("reset_valid_a", 32'(rvalid_a), 32'h0);
        check("reset_rdata_a", rdata_a,       32'h0);
        check("reset_err_a",   32'(err_a),    32'h0);
        check("reset_ready_b", 32'(ready_b),  32'h1);
        check("reset_busy_b",  32'(busy_b),   32'h0);
        check("reset_valid_b", 32'(rvalid_b), 32'h0);
        check("reset_rdata_b", rdata_b,       32'h0);
        check("reset_err_b",   32'(err_b),    32'h0);
        #1 rst = 1'b0;

        // The array powers up unknown; give both instances a known all-zero image.
        for (int w = 0; w < 256; w++) begin
            do_txn(1'b0, 1'b1, LW, 32'(w * 4), 32'h0, 1'b0, rd, er, lat, rl);
            do_txn(1'b1, 1'b1, LW, 32'(w * 4), 32'h0, 1'b0, rd, er, lat, rl);
        end

        for (int i = 0; i < 17; i++) begin
            do_txn(1'b0, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 1'b0, rd, er, lat, rl);
            model_apply(1'b0, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, mrd, mer);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), 32'(lat), vecs[i].exp_err ? 32'd1 : 32'd3);
            check($sformatf("vec%0d_ready_low", i), 32'(rl), 32'h1);
        end

        // req_valid held through the busy window: one accept, one pulse.
        for (int s = 0; s < 2; s++) begin
            n_acc = 0; n_pulse = 0;
            do_txn(1'(s), 1'b1, LW, 32'h40, 32'hCAFEF00D, 1'b1, rd, er, lat, rl);
            model_apply(1'(s), 1'b1, LW, 32'h40, 32'hCAFEF00D, mrd, mer);
            repeat (6) @(negedge clk);
            check($sformatf("hold%0d_accepts", s), 32'(n_acc), 32'h1);
            check($sformatf("hold%0d_pulses", s), 32'(n_pulse), 32'h1);
            check($sformatf("hold%0d_latency", s), 32'(lat), (s == 0) ? 32'd3 : 32'd1);
            check($sformatf("hold%0d_err", s), 32'(er), 32'h0);
            do_txn(1'(s), 1'b0, LW, 32'h40, 32'h0, 1'b0, rd, er, lat, rl);
            check($sformatf("hold%0d_readback", s), rd, 32'hCAFEF00D);
        end

        // Reset one cycle after the accept: the store is dropped and no response appears.
        n_pulse = 0; sel = 1'b0;
        @(posedge clk); #1;
        req_we = 1'b1; req_funct3 = LW; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
        req_valid = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", 32'(busy), 32'h0);
        repeat (5) @(negedge clk);
        check("rst_mid_pulses", 32'(n_pulse), 32'h0);
        do_txn(1'b0, 1'b0, LW, 32'h20, 32'h0, 1'b0, rd, er, lat, rl);
        check("rst_mid_readback", rd, 32'h0);

        // Reset on the edge that would commit the store.
        n_pulse = 0;
        @(posedge clk); #1;
        req_we = 1'b1; req_funct3 = LW; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
        req_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_commit_busy_before", 32'(busy), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_commit_busy", 32'(busy), 32'h0);
        repeat (5) @(negedge clk);
        check("rst_commit_pulses", 32'(n_pulse), 32'h0);
        do_txn(1'b0, 1'b0, LW, 32'h20, 32'h0, 1'b0, rd, er, lat, rl);
        check("rst_commit_readback", rd, 32'h0);

        for (int k = 0; k < 300; k++) begin
            bit          s;
            logic        we;
            logic [2:0]  f3;
            logic [31:0] addr, wdata;
            int          r;
            s  = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 3);
            if (r != 0) begin
                case ($urandom_range(0, 4))
                    0: f3 = LB;
                    1: f3 = LH;
                    2: f3 = LW;
                    3: f3 = LBU;
                    default: f3 = LHU;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            r = $urandom_range(0, 9);
            if (r < 8)       addr = 32'($urandom_range(0, 1023));
            else if (r == 8) addr = 32'($urandom_range(1024, 2047));
            else             addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            wdata = $urandom;
            model_apply(s, we, f3, addr, wdata, mrd, mer);
            do_txn(s, we, f3, addr, wdata, 1'b0, rd, er, lat, rl);
            check($sformatf("rnd%0d_rdata", k), rd, mrd);
            check($sformatf("rnd%0d_err", k), 32'(er), 32'(mer));
            check($sformatf("rnd%0d_latency", k), 32'(lat), (mer || s) ? 32'd1 : 32'd3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
